// File: rtl/boss_hit_ctrl_if.sv
// Boss hit controller bus: bullet/boss geometry in, explosion,
// respawn, hit and score status out.
interface boss_hit_ctrl_if;
  logic       move_tick;
  logic       bullet_valid;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic [9:0] boss_x;
  logic [9:0] boss_y;
  logic       boss_exist;
  logic       boom;
  logic       revive;
  logic       bullet_hit;
  logic [3:0] boss_hp;
  logic [7:0] kill_count;

  modport master (
    output move_tick, bullet_valid,
    output bullet_x, bullet_y,
    output boss_x, boss_y, boss_exist,
    input  boom, revive, bullet_hit,
    input  boss_hp, kill_count
  );

  modport slave (
    input  move_tick, bullet_valid,
    input  bullet_x, bullet_y,
    input  boss_x, boss_y, boss_exist,
    output boom, revive, bullet_hit,
    output boss_hp, kill_count
  );
endinterface

// File: rtl/boss_hit_ctrl.sv
// Boss hit controller: hitbox test, hit cooldown, hit points,
// explosion/respawn sequencing and kill counter.
module boss_hit_ctrl #(
  parameter int BOSS_W        = 50,
  parameter int BOSS_H        = 50,
  parameter int MAX_HP        = 8,
  parameter int HIT_COOLDOWN  = 4,
  parameter int BOOM_TICKS    = 32,
  parameter int RESPAWN_TICKS = 64
) (
  input logic             clk,
  input logic             rst,
  boss_hit_ctrl_if.slave  bus
);

  localparam int CW = (HIT_COOLDOWN > 0) ?
                      $clog2(HIT_COOLDOWN + 1) : 1;
  localparam int TMAX = (BOOM_TICKS > RESPAWN_TICKS) ?
                        BOOM_TICKS : RESPAWN_TICKS;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [1:0] {
    ALIVE,
    BOOM,
    RESPAWN
  } state_t;

  state_t          state_q;
  logic [3:0]      hp_q;
  logic [7:0]      kill_q;
  logic [CW-1:0]   cool_q;
  logic [TW-1:0]   tick_q;
  logic            boom_q;
  logic            revive_q;
  logic            hit_q;

  logic [10:0]     x_end;
  logic [10:0]     y_end;
  logic            in_box;
  logic            hit_d;

  // Hitbox far edges at 11 bits so a boss near 1023 cannot wrap.
  assign x_end = {1'b0, bus.boss_x} + 11'(BOSS_W);
  assign y_end = {1'b0, bus.boss_y} + 11'(BOSS_H);

  assign in_box = bus.bullet_valid && bus.boss_exist &&
                  (bus.bullet_x >= bus.boss_x) &&
                  ({1'b0, bus.bullet_x} < x_end) &&
                  (bus.bullet_y >= bus.boss_y) &&
                  ({1'b0, bus.bullet_y} < y_end);

  assign hit_d = in_box && (state_q == ALIVE) &&
                 (cool_q == '0) && (hp_q != 4'd0);

  // Life-cycle FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ALIVE;
      hp_q     <= 4'(MAX_HP);
      kill_q   <= 8'd0;
      cool_q   <= '0;
      tick_q   <= '0;
      boom_q   <= 1'b0;
      revive_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      revive_q <= 1'b0;
      hit_q    <= 1'b0;
      unique case (state_q)
        ALIVE: begin
          if (hit_d) begin
            hit_q  <= 1'b1;
            hp_q   <= hp_q - 4'd1;
            cool_q <= CW'(HIT_COOLDOWN);
            if (hp_q == 4'd1) begin
              state_q <= BOOM;
              boom_q  <= 1'b1;
              tick_q  <= '0;
              if (kill_q != 8'hFF)
                kill_q <= kill_q + 8'd1;
            end
          end else if (bus.move_tick && cool_q != '0) begin
            cool_q <= cool_q - CW'(1);
          end
        end
        BOOM: begin
          if (bus.move_tick) begin
            if (tick_q == TW'(BOOM_TICKS - 1)) begin
              state_q <= RESPAWN;
              boom_q  <= 1'b0;
              tick_q  <= '0;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        RESPAWN: begin
          if (bus.move_tick) begin
            if (tick_q == TW'(RESPAWN_TICKS - 1)) begin
              state_q  <= ALIVE;
              revive_q <= 1'b1;
              hp_q     <= 4'(MAX_HP);
              cool_q   <= '0;
              tick_q   <= '0;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: begin
          state_q <= ALIVE;
          boom_q  <= 1'b0;
          tick_q  <= '0;
        end
      endcase
    end
  end

  assign bus.boom       = boom_q;
  assign bus.revive     = revive_q;
  assign bus.bullet_hit = hit_q;
  assign bus.boss_hp    = hp_q;
  assign bus.kill_count = kill_q;

endmodule

// File: tb/tb_boss_hit_ctrl.sv
// Testbench for boss_hit_ctrl: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_boss_hit_ctrl;

  localparam int W     = 50;
  localparam int H     = 50;
  localparam int MAXHP = 8;
  localparam int COOL  = 4;
  localparam int BT    = 32;
  localparam int RT    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  boss_hit_ctrl_if bus ();

  boss_hit_ctrl #(
    .BOSS_W(W), .BOSS_H(H), .MAX_HP(MAXHP),
    .HIT_COOLDOWN(COOL), .BOOM_TICKS(BT),
    .RESPAWN_TICKS(RT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: phase 0 alive, 1 exploding, 2 waiting to respawn.
  int m_ph, m_hp, m_kill, m_cool, m_cnt;
  bit m_hit, m_rev;

  task automatic drive(input bit v, input int bx, input int by,
                       input int x, input int y, input bit ex,
                       input bit tk);
    bus.bullet_valid = v;
    bus.boss_x       = 10'(bx);
    bus.boss_y       = 10'(by);
    bus.bullet_x     = 10'(x);
    bus.bullet_y     = 10'(y);
    bus.boss_exist   = ex;
    bus.move_tick    = tk;
  endtask

  task automatic model_step();
    int bx, by, x, y;
    bit h;
    bx = int'(bus.boss_x);
    by = int'(bus.boss_y);
    x  = int'(bus.bullet_x);
    y  = int'(bus.bullet_y);
    h  = bus.bullet_valid && bus.boss_exist &&
         x >= bx && x < bx + W && y >= by && y < by + H;
    m_hit = 0;
    m_rev = 0;
    if (rst) begin
      m_ph = 0; m_hp = MAXHP; m_kill = 0;
      m_cool = 0; m_cnt = 0;
    end else if (m_ph == 0) begin
      if (h && m_cool == 0) begin
        m_hit  = 1;
        m_hp   = m_hp - 1;
        m_cool = COOL;
        if (m_hp == 0) begin
          m_ph   = 1;
          m_cnt  = 0;
          m_kill = (m_kill < 255) ? m_kill + 1 : 255;
        end
      end else if (bus.move_tick && m_cool > 0) begin
        m_cool = m_cool - 1;
      end
    end else if (bus.move_tick) begin
      m_cnt = m_cnt + 1;
      if (m_ph == 1 && m_cnt == BT) begin
        m_ph = 2; m_cnt = 0;
      end else if (m_ph == 2 && m_cnt == RT) begin
        m_ph = 0; m_cnt = 0; m_rev = 1;
        m_hp = MAXHP; m_cool = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    n_chk++;
    if (bus.boss_hp !== 4'd8 || bus.kill_count !== 8'd0 ||
        bus.boom !== 1'b0 || bus.revive !== 1'b0 ||
        bus.bullet_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got hp=%0d kill=%0d boom=%0d rev=%0d hit=%0d required hp=8 kill=0 boom=0 rev=0 hit=0",
               bus.boss_hp, bus.kill_count, bus.boom,
               bus.revive, bus.bullet_hit);
    end
  endtask

  task automatic test_hit_basic();
    do_reset();
    drive(1, 270, 0, 300, 20, 1, 0);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b1 || bus.boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL basic_hit: got hit=%0d hp=%0d required hit=1 hp=7",
               bus.bullet_hit, bus.boss_hp);
    end
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b0 || bus.boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL basic_pulse: got hit=%0d hp=%0d required hit=0 hp=7",
               bus.bullet_hit, bus.boss_hp);
    end
  endtask

  task automatic test_edges();
    do_reset();
    drive(1, 270, 0, 320, 20, 1, 0);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_right: got hit=%0d required 0",
               bus.bullet_hit);
    end
    drive(1, 270, 0, 269, 20, 1, 0);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_left: got hit=%0d required 0",
               bus.bullet_hit);
    end
    drive(1, 270, 0, 270, 50, 1, 0);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_bottom: got hit=%0d required 0",
               bus.bullet_hit);
    end
    drive(1, 270, 0, 319, 49, 1, 0);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b1 || bus.boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL edge_corner: got hit=%0d hp=%0d required hit=1 hp=7",
               bus.bullet_hit, bus.boss_hp);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 100, 100, 120, 120, 1, 1);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b1 || bus.boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL tick_hit: got hit=%0d hp=%0d required hit=1 hp=7",
               bus.bullet_hit, bus.boss_hp);
    end
    for (int i = 0; i < COOL; i++) begin
      cycle();
      n_chk++;
      if (bus.bullet_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL cooldown_hold: tick %0d got hit=%0d required 0",
                 i + 1, bus.bullet_hit);
      end
    end
    bus.move_tick = 1'b0;
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b1 || bus.boss_hp !== 4'd6) begin
      n_fail++;
      $display("FAIL cooldown_release: got hit=%0d hp=%0d required hit=1 hp=6",
               bus.bullet_hit, bus.boss_hp);
    end
  endtask

  task automatic test_cooldown_kill();
    int hits, ts, cyc;
    bit tk;
    do_reset();
    drive(1, 270, 0, 300, 20, 1, 0);
    hits = 0; ts = 0; cyc = 0;
    while (hits < 8 && cyc < 500) begin
      bus.move_tick = (cyc % 3 == 2);
      tk = bus.move_tick;
      cycle();
      if (bus.bullet_hit) begin
        if (hits > 0) begin
          n_chk++;
          if (ts != COOL) begin
            n_fail++;
            $display("FAIL hit_spacing: got %0d ticks required %0d",
                     ts, COOL);
          end
        end
        hits++;
        ts = 0;
      end else if (tk) begin
        ts++;
      end
      cyc++;
    end
    bus.move_tick = 1'b0;
    n_chk++;
    if (hits != 8) begin
      n_fail++;
      $display("FAIL kill_budget: got %0d hits required 8", hits);
    end
    n_chk++;
    if (bus.boss_hp !== 4'd0 || bus.boom !== 1'b1 ||
        bus.kill_count !== 8'd1) begin
      n_fail++;
      $display("FAIL kill_state: got hp=%0d boom=%0d kill=%0d required hp=0 boom=1 kill=1",
               bus.boss_hp, bus.boom, bus.kill_count);
    end
  endtask

  task automatic test_boom_respawn();
    int k, cyc;
    bit tk;
    k = 0; cyc = 0;
    while (k < BT + RT && cyc < 1000) begin
      bus.move_tick = (cyc % 2 == 1);
      tk = bus.move_tick;
      cycle();
      if (tk) k++;
      cyc++;
      n_chk++;
      if (bus.boom !== (k < BT)) begin
        n_fail++;
        $display("FAIL boom_level: tick %0d got boom=%0d required %0d",
                 k, bus.boom, (k < BT));
      end
      n_chk++;
      if (bus.bullet_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_while_dead: tick %0d got hit=%0d required 0",
                 k, bus.bullet_hit);
      end
      if (k < BT + RT) begin
        n_chk++;
        if (bus.revive !== 1'b0) begin
          n_fail++;
          $display("FAIL early_revive: tick %0d got revive=%0d required 0",
                   k, bus.revive);
        end
      end
    end
    n_chk++;
    if (k != BT + RT || bus.revive !== 1'b1 ||
        bus.boss_hp !== 4'd8) begin
      n_fail++;
      $display("FAIL revive: ticks=%0d got revive=%0d hp=%0d required ticks=%0d revive=1 hp=8",
               k, bus.revive, bus.boss_hp, BT + RT);
    end
    bus.bullet_valid = 1'b0;
    bus.move_tick = 1'b0;
    cycle();
    n_chk++;
    if (bus.revive !== 1'b0) begin
      n_fail++;
      $display("FAIL revive_pulse: got revive=%0d required 0",
               bus.revive);
    end
  endtask

  task automatic test_reset_mid_boom();
    int c;
    do_reset();
    drive(1, 500, 300, 510, 310, 1, 1);
    c = 0;
    while (!bus.boom && c < 200) begin
      cycle();
      c++;
    end
    n_chk++;
    if (bus.boom !== 1'b1) begin
      n_fail++;
      $display("FAIL midboom_setup: got boom=%0d required 1",
               bus.boom);
    end
    for (int i = 0; i < 9; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_chk++;
    if (bus.boom !== 1'b0 || bus.boss_hp !== 4'd8 ||
        bus.kill_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midboom_reset: got boom=%0d hp=%0d kill=%0d required boom=0 hp=8 kill=0",
               bus.boom, bus.boss_hp, bus.kill_count);
    end
    bus.move_tick = 1'b0;
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b1 || bus.boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL midboom_alive: got hit=%0d hp=%0d required hit=1 hp=7",
               bus.bullet_hit, bus.boss_hp);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 1000, 0, 1020, 10, 1, 0);
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b1 || bus.boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL wrap_hit: got hit=%0d hp=%0d required hit=1 hp=7",
               bus.bullet_hit, bus.boss_hp);
    end
    do_reset();
    drive(1, 1000, 0, 1020, 10, 0, 0);
    cycle();
    cycle();
    n_chk++;
    if (bus.bullet_hit !== 1'b0 || bus.boss_hp !== 4'd8) begin
      n_fail++;
      $display("FAIL no_exist: got hit=%0d hp=%0d required hit=0 hp=8",
               bus.bullet_hit, bus.boss_hp);
    end
  endtask

  task automatic test_saturate();
    int c;
    bit ok;
    do_reset();
    drive(1, 40, 40, 60, 60, 1, 1);
    ok = 1;
    for (int n = 0; n < 256; n++) begin
      c = 0;
      while (!bus.boom && c < 200) begin
        cycle();
        c++;
      end
      while (!bus.revive && c < 400) begin
        cycle();
        c++;
      end
      if (c >= 400) ok = 0;
    end
    bus.move_tick = 1'b0;
    n_chk++;
    if (!ok || bus.kill_count !== 8'd255) begin
      n_fail++;
      $display("FAIL kill_saturate: got kill=%0d budget_ok=%0d required kill=255",
               bus.kill_count, ok);
    end
  endtask

  task automatic test_random();
    int bx, by, x, y;
    logic [14:0] got, exp;
    do_reset();
    bx = 0; by = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) begin
        bx = $urandom_range(0, 1023);
        by = $urandom_range(0, 1023);
      end
      x = bx + int'($urandom_range(0, 60)) - 5;
      y = by + int'($urandom_range(0, 60)) - 5;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      drive($urandom_range(0, 9) < 8, bx, by, x, y,
            $urandom_range(0, 9) < 9,
            $urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cycle();
      got = {bus.boom, bus.revive, bus.bullet_hit,
             bus.boss_hp, bus.kill_count};
      exp = {(m_ph == 1), m_rev, m_hit,
             4'(m_hp), 8'(m_kill)};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: got boom/rev/hit/hp/kill=%b required %b",
                 i, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    m_ph = 0; m_hp = MAXHP; m_kill = 0;
    m_cool = 0; m_cnt = 0; m_hit = 0; m_rev = 0;
    test_reset();
    test_hit_basic();
    test_edges();
    test_back_to_back();
    test_cooldown_kill();
    test_boom_respawn();
    test_reset_mid_boom();
    test_wrap();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
